// File: rtl/traffic_sensor.sv
// Purpose: conditions two raw vehicle detectors, tracks per-road queue counts and drives the TAORB service request.
// Latency: detector step to count change is DEBOUNCE_CYCLES+2 cycles; TAORB moves one cycle after its switch condition holds.
// Backpressure: none; every input is sampled each cycle and all outputs are registered.
module traffic_sensor #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned DEPART_CYCLES   = 3,
    parameter int unsigned MIN_HOLD        = 8,
    parameter int unsigned CNT_W           = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sens_a,
    input  logic             sens_b,
    input  logic [5:0]       led,
    output logic             TAORB,
    output logic [CNT_W-1:0] count_a,
    output logic [CNT_W-1:0] count_b,
    output logic             err_led
);

    // Counter widths sized so each counter can hold its own terminal value.
    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned DEP_W  = $clog2(DEPART_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(MIN_HOLD + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEP_W-1:0]  DEP_LAST  = DEP_W'(DEPART_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MIN_HOLD);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;

    // Legal light codes driven by the controller.
    localparam logic [5:0] LED_A_GREEN  = 6'b001100;
    localparam logic [5:0] LED_A_YELLOW = 6'b010100;
    localparam logic [5:0] LED_B_GREEN  = 6'b100001;
    localparam logic [5:0] LED_B_YELLOW = 6'b100010;

    // Road index 0 is A (main), index 1 is B (side).
    localparam int ROAD_A = 0;
    localparam int ROAD_B = 1;

    typedef enum logic {
        SERVE_A = 1'b0,
        SERVE_B = 1'b1
    } state_t;

    // Two-flop synchronizer stages.
    logic [1:0]            sync1_q;
    logic [1:0]            sync2_q;

    // Debounce state.
    logic [1:0]            deb_lvl_q, deb_lvl_d;
    logic [1:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]            arrival;

    // Light decode and departure state.
    logic [1:0]            green;
    logic                  led_legal;
    logic                  err_q, err_d;
    logic [1:0][DEP_W-1:0] dep_cnt_q, dep_cnt_d;
    logic [1:0]            depart;

    // Queue counts.
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Arbitration state.
    state_t                state_q;
    logic                  taorb_q;
    logic [HOLD_W-1:0]     hold_q;
    logic                  hold_met;

    // Bring the asynchronous detectors into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {sens_b, sens_a};
            sync2_q <= sync1_q;
        end
    end

    // Debounce each road: the level only follows the sample after it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles. A rising flip of the
    // level is the arrival, reported in the same cycle the level updates so the
    // count lands together with the debounced level.
    always_comb begin
        deb_lvl_d = deb_lvl_q;
        deb_cnt_d = deb_cnt_q;
        arrival   = 2'b00;
        for (int r = 0; r < 2; r++) begin
            if (sync2_q[r] == deb_lvl_q[r]) begin
                deb_cnt_d[r] = '0;
            end else if (deb_cnt_q[r] == DEB_LAST) begin
                deb_lvl_d[r] = sync2_q[r];
                deb_cnt_d[r] = '0;
                arrival[r]   = sync2_q[r];
            end else begin
                deb_cnt_d[r] = deb_cnt_q[r] + 1'b1;
            end
        end
    end

    // Debounce registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_lvl_q <= 2'b00;
            deb_cnt_q <= '0;
        end else begin
            deb_lvl_q <= deb_lvl_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Decode the light bus; any code outside the four legal ones is an error
    // and is never treated as green for either road.
    always_comb begin
        green[ROAD_A] = (led == LED_A_GREEN);
        green[ROAD_B] = (led == LED_B_GREEN);
        led_legal     = (led == LED_A_GREEN)  || (led == LED_A_YELLOW) ||
                        (led == LED_B_GREEN)  || (led == LED_B_YELLOW);
        err_d         = !led_legal;
    end

    // Count green cycles per road; every DEPART_CYCLES of unbroken green is one
    // vehicle leaving. Any non-green cycle restarts the run.
    always_comb begin
        dep_cnt_d = dep_cnt_q;
        depart    = 2'b00;
        for (int r = 0; r < 2; r++) begin
            if (!green[r]) begin
                dep_cnt_d[r] = '0;
            end else if (dep_cnt_q[r] == DEP_LAST) begin
                dep_cnt_d[r] = '0;
                depart[r]    = 1'b1;
            end else begin
                dep_cnt_d[r] = dep_cnt_q[r] + 1'b1;
            end
        end
    end

    // Departure counters and the registered illegal-code flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            dep_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            dep_cnt_q <= dep_cnt_d;
            err_q     <= err_d;
        end
    end

    // Queue update: arrivals add, departures subtract, both together cancel.
    // Both directions saturate so a noisy detector or a long green can never
    // wrap the count.
    always_comb begin
        cnt_d = cnt_q;
        for (int r = 0; r < 2; r++) begin
            if (arrival[r] && !depart[r]) begin
                if (cnt_q[r] != CNT_MAX) begin
                    cnt_d[r] = cnt_q[r] + 1'b1;
                end
            end else if (depart[r] && !arrival[r]) begin
                if (cnt_q[r] != CNT_ZERO) begin
                    cnt_d[r] = cnt_q[r] - 1'b1;
                end
            end
        end
    end

    // Queue count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hold_met = (hold_q >= HOLD_MAX);

    // Arbitration: switch only after the minimum hold, towards the longer
    // queue, with A winning ties; an empty system keeps whatever it serves.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SERVE_A;
            taorb_q <= 1'b1;
            hold_q  <= '0;
        end else begin
            case (state_q)
                SERVE_A: begin
                    if (hold_met && (cnt_q[ROAD_B] > cnt_q[ROAD_A])) begin
                        state_q <= SERVE_B;
                        taorb_q <= 1'b0;
                        hold_q  <= '0;
                    end else if (!hold_met) begin
                        hold_q  <= hold_q + 1'b1;
                    end
                end
                SERVE_B: begin
                    if (hold_met && (cnt_q[ROAD_A] >= cnt_q[ROAD_B]) &&
                        !((cnt_q[ROAD_A] == CNT_ZERO) && (cnt_q[ROAD_B] == CNT_ZERO))) begin
                        state_q <= SERVE_A;
                        taorb_q <= 1'b1;
                        hold_q  <= '0;
                    end else if (!hold_met) begin
                        hold_q  <= hold_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= SERVE_A;
                    taorb_q <= 1'b1;
                    hold_q  <= '0;
                end
            endcase
        end
    end

    assign TAORB   = taorb_q;
    assign count_a = cnt_q[ROAD_A];
    assign count_b = cnt_q[ROAD_B];
    assign err_led = err_q;

endmodule

// File: doc/traffic_sensor.md
Name: traffic_sensor

Overview:
Detector front-end that produces the TAORB request consumed by the traffic light controller and observes that controller's 6-bit led bus. It conditions two raw vehicle detectors (road A = main, road B = side) and keeps per-road queue counts. Arrivals come from detector pulses; departures come from green time observed on led. An arbitration FSM with minimum hold time drives TAORB (1 = serve A, 0 = serve B).

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples needed before the debounced level changes (>=1).
DEPART_CYCLES, 3, cycles of observed green per vehicle departure (>=1).
MIN_HOLD, 8, minimum cycles TAORB must hold a value before it may toggle (>=1).
CNT_W, 4, width of each queue counter.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
sens_a  input  1  raw asynchronous detector, road A; high while a vehicle is present.
sens_b  input  1  raw asynchronous detector, road B.
led  input  6  light bus from the controller.
TAORB  output  1  1 = request service for A, 0 = request service for B.
count_a  output  CNT_W  road A queue count.
count_b  output  CNT_W  road B queue count.
err_led  output  1  high in any cycle where led holds an illegal code.

Behaviour:
- Reset, synchronous on rst=1 at a clk edge:
  - TAORB=1, count_a=0, count_b=0, err_led=0.
  - Synchronizers, debounced levels, debounce counters, departure counters and hold counter all go to 0. FSM goes to SERVE_A.
  - Reset asserted mid-operation aborts everything the same way.
- Sync: each sens_x passes through 2 flops before use.
- Debounce, per road:
  - A counter tracks how many consecutive cycles the synced sample has differed from the debounced level.
  - The count clears when the sample equals the debounced level.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the sample value and the count clears.
  - Net latency: a clean step on sens_x reaches the debounced level DEBOUNCE_CYCLES+2 cycles after the first sampling edge.
- Arrival: a 0->1 transition of the debounced level is one arrival pulse. Pulses shorter than DEBOUNCE_CYCLES synced cycles produce no arrival.
- led decode:
  - 6'b001100 = A green, 6'b010100 = A yellow.
  - 6'b100001 = B green, 6'b100010 = B yellow.
  - Any other value: err_led=1 registered, so it asserts the cycle after the illegal value is sampled. That cycle counts as no green for either road.
- Departure, per road:
  - The departure counter increments each cycle its road is green. Otherwise it clears.
  - On reaching DEPART_CYCLES it clears and emits one departure.
  - Departure on a count of 0 is ignored.
- Count update, per road, in the same cycle:
  - Arrival only: +1, saturating at 2^CNT_W-1.
  - Departure only: -1, saturating at 0.
  - Arrival and departure together: unchanged.
  - Counts are registered outputs.
- Arbitration FSM, states SERVE_A (TAORB=1) and SERVE_B (TAORB=0):
  - The hold counter increments each cycle, saturating at MIN_HOLD. It clears on every state change.
  - SERVE_A -> SERVE_B when hold >= MIN_HOLD and count_b > count_a.
  - SERVE_B -> SERVE_A when hold >= MIN_HOLD and count_a >= count_b, and not both counts are 0. A wins ties.
  - Both counts 0: stay in the current state.
  - TAORB is registered and changes the cycle after the transition condition is true.
- Widths: counts compare unsigned. No wrap anywhere; all counters saturate.

Test Plan:
- Reset hold, then release with all inputs 0 and led=6'b001100 -> TAORB=1, counts 0, err_led=0 for 50 cycles.
- sens_b high 3 cycles, then low, DEBOUNCE_CYCLES=4 -> count_b stays 0 (glitch rejected).
- sens_b high 10 cycles, led=6'b001100 -> count_b=1 at cycle 6 after the first sampling edge. TAORB goes 0 once hold>=8 (count_b=1 > count_a=0).
- count_b=2, led=6'b100001 held 6 cycles -> count_b 2->1->0, stepping every 3 cycles. With count_a=1, TAORB returns to 1 after MIN_HOLD.
- Arrival on A coinciding with a departure on A (count_a=3, A green) -> count_a stays 3. 20 arrivals with no green -> count_a saturates at 15.
- led=6'b111111 for 1 cycle -> err_led=1 for exactly 1 cycle, no departure counted. rst asserted mid-count -> all outputs at reset values on the next edge.
